// File: rtl/bitcoin_pkg.sv
// Shared types, constants and the compact-target overflow rule used by the
// nBits decoder.
package bitcoin_pkg;

  localparam int NBITS_W  = 32;
  localparam int EXP_BIAS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctd_state_t;

  // True when mant * 256^(exp-3) needs more than nb bytes. The three terms
  // cover mantissas of one, two and three significant bytes.
  function automatic logic compact_ovf(input logic [7:0] exp,
                                       input logic [22:0] mant,
                                       input int unsigned nb);
    int unsigned e;
    e = 32'(exp);
    return (mant != '0) &&
           ((e > nb + 2) ||
            ((mant > 23'h0000ff) && (e > nb + 1)) ||
            ((mant > 23'h00ffff) && (e > nb)));
  endfunction

endpackage

// File: rtl/compact_target_decoder_seq_if.sv
// Request/result bundle between the config registers, the decoder and the
// hash-vs-target comparator.
//
// Handshake: both sides use valid/ready. A transfer happens on a rising clock
// edge where valid and ready are both 1. While valid is 1 the sender keeps its
// payload stable and does not drop valid until the transfer happens; ready may
// toggle freely and never depends combinationally on valid.
interface compact_target_decoder_seq_if #(
  parameter int TARGET_W = 256
);
  logic [bitcoin_pkg::NBITS_W-1:0] nbits_i;
  logic                            in_valid_i;
  logic                            in_ready_o;
  logic [TARGET_W-1:0]             target_o;
  logic                            negative_o;
  logic                            overflow_o;
  logic                            out_valid_o;
  logic                            out_ready_i;

  // Driving side: supplies nbits and consumes the result.
  modport master (
    output nbits_i, in_valid_i, out_ready_i,
    input  in_ready_o, target_o, negative_o, overflow_o, out_valid_o
  );

  // Decoder side.
  modport slave (
    input  nbits_i, in_valid_i, out_ready_i,
    output in_ready_o, target_o, negative_o, overflow_o, out_valid_o
  );
endinterface

// File: rtl/target_byte_shl.sv
// Combinational left shift by a whole number of bytes (0..STEP_BYTES).
module target_byte_shl #(
  parameter int TARGET_W   = 256,
  parameter int STEP_BYTES = 1,
  localparam int CW        = $clog2(STEP_BYTES + 1)
) (
  input  logic [TARGET_W-1:0] data,
  input  logic [CW-1:0]       count,
  output logic [TARGET_W-1:0] shifted
);

  logic [CW+2:0] shamt;

  // Byte count to bit count; upper bits fall off the top.
  always_comb begin
    shamt   = {count, 3'b000};
    shifted = data << shamt;
  end

endmodule

// File: rtl/compact_target_decoder_seq.sv
// Iterative nBits -> full target decoder. Flags and small exponents resolve on
// the accept edge; larger exponents shift the mantissa up STEP_BYTES bytes per
// cycle until the byte count is exhausted.
module compact_target_decoder_seq
  import bitcoin_pkg::*;
#(
  parameter int TARGET_W   = 256,
  parameter int STEP_BYTES = 1
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  compact_target_decoder_seq_if.slave  bus,
  output logic                         busy_o,
  output ctd_state_t                   state_o
);

  localparam int          CW    = $clog2(STEP_BYTES + 1);
  localparam int unsigned NB    = TARGET_W / 8;
  localparam logic [7:0]  STEP8 = 8'(STEP_BYTES);
  localparam logic [7:0]  BIAS8 = 8'(EXP_BIAS);

  ctd_state_t          state_q, state_d;
  logic [TARGET_W-1:0] acc_q;
  logic [7:0]          cnt_q;
  logic                neg_q, ovf_q;

  // Field split and flag evaluation on the incoming word.
  logic [7:0]          exp_f;
  logic [22:0]         mant_f;
  logic                neg_in, ovf_in, small_exp, accept;
  logic [1:0]          rbytes;
  logic [TARGET_W-1:0] mant_ext, rshift_val;

  // SHIFT-step signals.
  logic [CW-1:0]       step;
  logic [7:0]          cnt_next;
  logic                shift_last;
  logic [TARGET_W-1:0] shl_out;

  // Decode the incoming word and precompute the small-exponent result.
  always_comb begin
    exp_f      = bus.nbits_i[31:24];
    mant_f     = bus.nbits_i[22:0];
    neg_in     = bus.nbits_i[23] && (mant_f != '0);
    ovf_in     = compact_ovf(exp_f, mant_f, NB);
    small_exp  = (exp_f <= BIAS8);
    rbytes     = 2'(BIAS8 - exp_f);
    mant_ext   = TARGET_W'(mant_f);
    rshift_val = mant_ext >> {rbytes, 3'b000};
    accept     = bus.in_valid_i && (state_q == IDLE);
  end

  // Bytes to shift this cycle: a full step, or the remainder on the last one.
  always_comb begin
    step       = (cnt_q >= STEP8) ? CW'(STEP_BYTES) : CW'(cnt_q);
    cnt_next   = cnt_q - 8'(step);
    shift_last = (cnt_next == '0);
  end

  target_byte_shl #(
    .TARGET_W   (TARGET_W),
    .STEP_BYTES (STEP_BYTES)
  ) u_shl (
    .data    (acc_q),
    .count   (step),
    .shifted (shl_out)
  );

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (neg_in || ovf_in || small_exp) state_d = DONE;
          else                               state_d = SHIFT;
        end
      end
      SHIFT: if (shift_last) state_d = DONE;
      DONE:  if (bus.out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulator, byte counter and latched flags.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            neg_q <= neg_in;
            ovf_q <= ovf_in;
            if (neg_in || ovf_in) begin
              acc_q <= '0;
              cnt_q <= '0;
            end else if (small_exp) begin
              acc_q <= rshift_val;
              cnt_q <= '0;
            end else begin
              acc_q <= mant_ext;
              cnt_q <= exp_f - BIAS8;
            end
          end
        end
        SHIFT: begin
          acc_q <= shl_out;
          cnt_q <= cnt_next;
        end
        default: ;
      endcase
    end
  end

  // Outputs follow registered state directly.
  always_comb begin
    bus.in_ready_o  = (state_q == IDLE);
    bus.out_valid_o = (state_q == DONE);
    bus.target_o    = acc_q;
    bus.negative_o  = neg_q;
    bus.overflow_o  = ovf_q;
    busy_o          = (state_q != IDLE);
    state_o         = state_q;
  end

endmodule

// File: tb/tb_compact_target_decoder_seq.sv
// Directed bench for compact_target_decoder_seq: three instances (STEP_BYTES
// 1, 2, 4) share one stimulus stream and are checked against a byte-length
// reference model.
module tb_compact_target_decoder_seq;
  import bitcoin_pkg::*;

  localparam int TW = 256;

  // ---------------- clock / reset ----------------
  logic clk, rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] nbits;
  logic        in_valid, out_ready;

  compact_target_decoder_seq_if #(.TARGET_W(TW)) bus1 ();
  compact_target_decoder_seq_if #(.TARGET_W(TW)) bus2 ();
  compact_target_decoder_seq_if #(.TARGET_W(TW)) bus4 ();

  assign bus1.nbits_i = nbits;  assign bus1.in_valid_i = in_valid;  assign bus1.out_ready_i = out_ready;
  assign bus2.nbits_i = nbits;  assign bus2.in_valid_i = in_valid;  assign bus2.out_ready_i = out_ready;
  assign bus4.nbits_i = nbits;  assign bus4.in_valid_i = in_valid;  assign bus4.out_ready_i = out_ready;

  logic [TW-1:0] tgt [3];
  logic [2:0]    ov, ir, ng, of, busy;
  ctd_state_t    st [3];

  assign tgt[0] = bus1.target_o;  assign tgt[1] = bus2.target_o;  assign tgt[2] = bus4.target_o;
  assign ov = {bus4.out_valid_o, bus2.out_valid_o, bus1.out_valid_o};
  assign ir = {bus4.in_ready_o,  bus2.in_ready_o,  bus1.in_ready_o};
  assign ng = {bus4.negative_o,  bus2.negative_o,  bus1.negative_o};
  assign of = {bus4.overflow_o,  bus2.overflow_o,  bus1.overflow_o};

  compact_target_decoder_seq #(.TARGET_W(TW), .STEP_BYTES(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus1.slave), .busy_o(busy[0]), .state_o(st[0]));
  compact_target_decoder_seq #(.TARGET_W(TW), .STEP_BYTES(2)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus2.slave), .busy_o(busy[1]), .state_o(st[1]));
  compact_target_decoder_seq #(.TARGET_W(TW), .STEP_BYTES(4)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus4.slave), .busy_o(busy[2]), .state_o(st[2]));

  // ---------------- scoreboard ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [TW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int step_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  // Reference: size the mantissa in bytes and check the top byte position.
  function automatic void model(input logic [31:0] nb, output logic [TW-1:0] t,
                                output logic neg, output logic ovf);
    int unsigned e, len;
    logic [22:0] m;
    e   = 32'(nb[31:24]);
    m   = nb[22:0];
    len = (m > 23'h00ffff) ? 3 : ((m > 23'h0000ff) ? 2 : 1);
    neg = nb[23] && (m != 0);
    ovf = (m != 0) && (e > 3) && ((e - 3 + len) > TW / 8);
    if (neg || ovf)  t = '0;
    else if (e <= 3) t = TW'(m) >> (8 * (3 - e));
    else             t = TW'(m) << (8 * (e - 3));
  endfunction

  function automatic int model_lat(input logic [31:0] nb, input int s);
    logic [TW-1:0] t;
    logic neg, ovf;
    int unsigned e;
    model(nb, t, neg, ovf);
    e = 32'(nb[31:24]);
    if (neg || ovf || e <= 3) return 1;
    return 1 + int'((e - 3 + s - 1) / s);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_case(input string tag, input logic [31:0] nb);
    logic [TW-1:0] t;
    logic neg, ovf;
    logic [2:0] done;
    int c;
    model(nb, t, neg, ovf);
    exp_q.push_back(t);
    @(negedge clk);
    check({tag, " in_ready"}, TW'(ir), TW'(3'b111));
    nbits = nb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    c = 1;
    done = '0;
    while (done != 3'b111 && c < 200) begin
      for (int k = 0; k < 3; k++) begin
        if (!done[k] && ov[k]) begin
          done[k] = 1'b1;
          check($sformatf("%s/S%0d target", tag, step_of(k)), tgt[k], exp_q[0]);
          check($sformatf("%s/S%0d neg", tag, step_of(k)), TW'(ng[k]), TW'(neg));
          check($sformatf("%s/S%0d ovf", tag, step_of(k)), TW'(of[k]), TW'(ovf));
          check($sformatf("%s/S%0d latency", tag, step_of(k)), TW'(c), TW'(model_lat(nb, step_of(k))));
        end
      end
      if (done != 3'b111) begin
        @(negedge clk);
        c++;
      end
    end
    if (done != 3'b111) check({tag, " timeout"}, TW'(done), TW'(3'b111));
    void'(exp_q.pop_front());
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [TW-1:0] t1;
    logic n1, o1;
    int c;
    rst = 1'b1; nbits = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst out_valid", TW'(ov), '0);
    check("rst busy", TW'(busy), '0);
    check("rst in_ready", TW'(ir), TW'(3'b111));
    check("rst flags", TW'({ng, of}), '0);
    for (int k = 0; k < 3; k++) check($sformatf("rst target%0d", k), tgt[k], '0);
    rst = 1'b0;

    run_case("genesis",   32'h1d00ffff);
    check("genesis const", TW'(256'hffff) << 208, 256'h0000ffff << 208);
    run_case("exp3",      32'h03123456);
    run_case("exp1",      32'h01123456);
    run_case("exp2_zero", 32'h02000012);
    run_case("exp0",      32'h00123456);
    run_case("neg",       32'h04923456);
    run_case("ovf35",     32'h23000001);
    run_case("ovf34",     32'h22010000);
    run_case("edge33",    32'h21000100);
    run_case("edge32",    32'h207fffff);
    run_case("ovf33",     32'h217fffff);
    run_case("mant0",     32'h1d000000);
    run_case("signzero",  32'h1d800000);

    // Backpressure: result must hold and new requests must be ignored.
    model(32'h1d00ffff, t1, n1, o1);
    @(negedge clk);
    nbits = 32'h1d00ffff; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    c = 0;
    while (ov != 3'b111 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("bp reach done", TW'(ov), TW'(3'b111));
    for (int i = 0; i < 10; i++) begin
      nbits = 32'h03123456; in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("bp%0d out_valid", i), TW'(ov), TW'(3'b111));
      check($sformatf("bp%0d in_ready", i), TW'(ir), '0);
      for (int k = 0; k < 3; k++) check($sformatf("bp%0d target%0d", i, k), tgt[k], t1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp release out_valid", TW'(ov), '0);
    check("bp release in_ready", TW'(ir), TW'(3'b111));
    check("bp release busy", TW'(busy), '0);

    // Reset in the middle of SHIFT.
    nbits = 32'h1d00ffff; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid shift busy", TW'(busy), TW'(3'b111));
    rst = 1'b1;
    @(negedge clk);
    check("midrst out_valid", TW'(ov), '0);
    check("midrst in_ready", TW'(ir), TW'(3'b111));
    for (int k = 0; k < 3; k++) check($sformatf("midrst target%0d", k), tgt[k], '0);
    rst = 1'b0;
    run_case("after_rst", 32'h1d00ffff);

    // Random sweep across exponent range, sign and mantissa sizes.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] r;
      r[31:24] = 8'($urandom_range(0, 40));
      r[23]    = 1'($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       r[22:0] = 23'($urandom_range(0, 8'hff));
        1:       r[22:0] = 23'($urandom_range(0, 16'hffff));
        default: r[22:0] = 23'($urandom_range(0, 23'h7fffff));
      endcase
      run_case($sformatf("rand%0d_%08h", i, r), r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
